// File: rtl/instr_feeder_pkg.sv
// feeder_pkg: shared definitions for the instruction feeder.
//   - feeder_state_e : issue sequencer states (HALTED is only reachable when
//                      FEEDER_SYSTEM_HALT_EN is defined)
//   - NOP_INSTR      : default bubble word, addi x0,x0,0
//   - OPC_*          : RV32I major opcodes used by the multi-cycle core
//   - is_system()    : true when a word carries the SYSTEM opcode
package feeder_pkg;

  typedef enum logic [1:0] {
    FETCH       = 2'd0,
    EXEC_REAL   = 2'd1,
    EXEC_BUBBLE = 2'd2,
    HALTED      = 2'd3
  } feeder_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic is_system(input logic [31:0] instr);
    return instr[6:0] == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/instr_feeder_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with zero-latency show-ahead head.
// Ports:
//   clk, reset (async, active-low)
//   push, push_data  : enqueue request; dropped when full unless popping
//   pop              : dequeue request; ignored when empty
//   head             : word at the read pointer, valid whenever !empty
//   full, empty, count, overflow (sticky, set by a dropped push)
// Storage has no reset; clearing the pointers discards the contents.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a push at full is still
  // accepted when it coincides with a pop.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && !do_push)
        overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
  end

  assign head     = mem[rd_ptr_reg];
  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: instruction queue and issue sequencer in front of the
// multi-cycle core.
// Ports:
//   clk, reset (async, active-low; the core is reset from the same source)
//   wr_en, wr_data  : push an instruction word into the queue
//   run             : issue enable; when low only bubbles are issued
//   core_done       : core finished the current instruction
//   command         : word presented to the core (sampled when fetch_slot)
//   fetch_slot      : the core samples command at the end of this cycle
//   full, empty, count, overflow : queue status
//   retired_count   : real instructions completed (wraps)
//   busy            : a real instruction is executing
//   halted          : only with FEEDER_SYSTEM_HALT_EN; a SYSTEM word stopped
//                     issue until run is cycled low then high
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] NOP_WORD = NOP_INSTR,
  parameter int          CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  input  logic                        run,
  input  logic                        core_done,
  output logic [31:0]                 command,
  output logic                        fetch_slot,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow,
  output logic [CNT_W-1:0]            retired_count,
  output logic                        busy
`ifdef FEEDER_SYSTEM_HALT_EN
  ,
  output logic                        halted
`endif
);

  feeder_state_e    state_reg;
  logic             fetch_slot_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] retired_reg;
  logic [31:0]      fifo_head;
  logic             fifo_empty;
  logic             at_fetch;
  logic             head_valid;
  logic             pop;
  logic             issue;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (fifo_empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign at_fetch   = (state_reg == FETCH);
  assign head_valid = run && !fifo_empty;
  assign pop        = at_fetch && head_valid;

`ifdef FEEDER_SYSTEM_HALT_EN
  logic halted_reg;
  logic armed_reg;    // run seen low while halted
  logic release_reg;  // run seen high after armed
  logic halt_take;

  // A SYSTEM word at the head is consumed but never shown to the core.
  assign halt_take = pop && is_system(fifo_head);
  assign issue     = pop && !halt_take;
  assign halted    = halted_reg;
`else
  assign issue = pop;
`endif

  // Outside an issuing fetch cycle the core ignores command; hold the bubble.
  assign command = issue ? fifo_head : NOP_WORD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= FETCH;
      fetch_slot_reg <= 1'b1;
      busy_reg       <= 1'b0;
      retired_reg    <= '0;
`ifdef FEEDER_SYSTEM_HALT_EN
      halted_reg     <= 1'b0;
      armed_reg      <= 1'b0;
      release_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        FETCH: begin
          // core_done cannot legally occur here and is ignored.
          fetch_slot_reg <= 1'b0;
`ifdef FEEDER_SYSTEM_HALT_EN
          if (halt_take) begin
            state_reg   <= HALTED;
            halted_reg  <= 1'b1;
            armed_reg   <= 1'b0;
            release_reg <= 1'b0;
          end else
`endif
          if (issue) begin
            state_reg <= EXEC_REAL;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= EXEC_BUBBLE;
          end
        end
        EXEC_REAL, EXEC_BUBBLE: begin
          if (core_done) begin
            if (state_reg == EXEC_REAL)
              retired_reg <= retired_reg + CNT_W'(1);
            state_reg      <= FETCH;
            fetch_slot_reg <= 1'b1;
            busy_reg       <= 1'b0;
          end
        end
`ifdef FEEDER_SYSTEM_HALT_EN
        HALTED: begin
          // The core keeps executing bubbles, so fetch slots are still
          // tracked here; fetch_slot_reg marks a halted fetch slot.
          if (!run)
            armed_reg <= 1'b1;
          if (armed_reg && run)
            release_reg <= 1'b1;
          if (core_done && !fetch_slot_reg) begin
            fetch_slot_reg <= 1'b1;
            if (release_reg || (armed_reg && run)) begin
              state_reg   <= FETCH;
              halted_reg  <= 1'b0;
              armed_reg   <= 1'b0;
              release_reg <= 1'b0;
            end
          end else begin
            fetch_slot_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg      <= FETCH;
          fetch_slot_reg <= 1'b1;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_slot    = fetch_slot_reg;
  assign busy          = busy_reg;
  assign retired_count = retired_reg;
  assign empty         = fifo_empty;

`ifndef SYNTHESIS
  // The core cannot finish an instruction in the cycle it fetches it.
  a_no_done_in_fetch: assert property (
    @(posedge clk) disable iff (!reset) fetch_slot_reg |-> !core_done
  );
`endif

endmodule

// File: tb/tb_instr_feeder.sv
`timescale 1ns/1ps
module tb_instr_feeder;

  localparam int          DEPTH = 16;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FEEDER_SYSTEM_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          run = 1'b0;
  logic          core_done = 1'b0;
  logic [31:0]   command;
  logic          fetch_slot;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   retired_count;
  logic          busy;
`ifdef FEEDER_SYSTEM_HALT_EN
  logic          halted;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents plus what the core is doing.
  logic [31:0] q[$];
  bit          m_slot;      // next cycle is a fetch slot
  bit          m_real;      // in-flight instruction is a real one
  bit          m_overflow;
  bit          m_halted;
  bit          m_armed;
  bit          m_release;
  int unsigned m_retired;
  int          lat_left;
  int          fixed_lat;   // 0 selects a random 1..4 cycle core latency
  logic [31:0] last_issued;

  always #5 clk = ~clk;

  instr_feeder #(.DEPTH(DEPTH), .NOP_WORD(NOP), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .run           (run),
    .core_done     (core_done),
    .command       (command),
    .fetch_slot    (fetch_slot),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .retired_count (retired_count),
    .busy          (busy)
`ifdef FEEDER_SYSTEM_HALT_EN
    ,
    .halted        (halted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'b0010011;  // OP-IMM, never SYSTEM
    return w;
  endfunction

  task automatic check_state();
    check("count", 32'(count), q.size());
    check("empty", 32'(empty), (q.size() == 0) ? 1 : 0);
    check("full", 32'(full), (q.size() == DEPTH) ? 1 : 0);
    check("overflow", 32'(overflow), 32'(m_overflow));
    check("retired", retired_count, m_retired);
    check("busy", 32'(busy), 32'(m_real));
`ifdef FEEDER_SYSTEM_HALT_EN
    check("halted", 32'(halted), 32'(m_halted));
`endif
  endtask

  // Entered and left at a falling edge. Drives one clock of stimulus,
  // plays the core, checks the fetch-slot view, advances the model.
  task automatic cycle(input bit push, input logic [31:0] data, input bit run_v);
    bit done, pop, issue, leave;
    logic [31:0] exp_cmd;
    wr_en = push;
    wr_data = data;
    run = run_v;
    done = 1'b0;
    if (!m_slot) begin
      if (lat_left > 0) lat_left--;
      done = (lat_left == 0);
    end
    core_done = done;
    #1;
    check("fetch_slot", 32'(fetch_slot), 32'(m_slot));
    pop = 1'b0;
    issue = 1'b0;
    exp_cmd = NOP;
    if (m_slot) begin
      if (!m_halted && run_v && q.size() > 0) begin
        pop = 1'b1;
        issue = !(HALT_EN && q[0][6:0] == 7'b1110011);
        if (issue) exp_cmd = q[0];
      end
      check("command", command, exp_cmd);
      if (issue) last_issued = command;
      $display("t=%0t slot cmd=%h issued=%0d retired=%0d queued=%0d",
               $time, command, issue, retired_count, q.size());
      lat_left = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
    end
    if (m_halted) begin
      leave = !m_slot && done && (m_release || (m_armed && run_v));
      if (m_armed && run_v) m_release = 1'b1;
      if (!run_v) m_armed = 1'b1;
      if (leave) begin
        m_halted = 1'b0; m_armed = 1'b0; m_release = 1'b0; m_slot = 1'b1;
      end else begin
        m_slot = !m_slot && done;
      end
    end else if (m_slot) begin
      if (pop) void'(q.pop_front());
      m_real = issue;
      if (pop && !issue) begin
        m_halted = 1'b1; m_armed = 1'b0; m_release = 1'b0;
      end
      m_slot = 1'b0;
    end else if (done) begin
      if (m_real) m_retired++;
      m_real = 1'b0;
      m_slot = 1'b1;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(data);
      else m_overflow = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    core_done = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wr_en = 1'b0;
    run = 1'b0;
    core_done = 1'b0;
    q.delete();
    m_slot = 1'b1; m_real = 1'b0; m_overflow = 1'b0; m_retired = 0;
    m_halted = 1'b0; m_armed = 1'b0; m_release = 1'b0; lat_left = 0;
    #1;  // before any clock edge: reset must act asynchronously
    check("rst_fetch_slot", 32'(fetch_slot), 1);
    check("rst_command", command, NOP);
    check_state();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until_slot(input bit run_v, input int budget);
    for (int i = 0; i < budget && !m_slot; i++) cycle(1'b0, '0, run_v);
    check("slot_timeout", 32'(m_slot), 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q.size() > 0 || m_real); i++) cycle(1'b0, '0, 1'b1);
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    logic [31:0] words [3];
    logic [31:0] marker;
    words[0] = 32'h0050_0093;
    words[1] = 32'h0030_8113;
    words[2] = 32'h0020_81B3;
    fixed_lat = 0;
    last_issued = '0;
    @(negedge clk);
    do_reset();

    // Three known words, core latency 3.
    fixed_lat = 3;
    for (int i = 0; i < 3; i++) cycle(1'b1, words[i], 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);
    check("a_retired", retired_count, 3);
    check("a_last", last_issued, words[2]);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    check("a_retired_held", retired_count, 3);

    // Empty queue with run high, then one word mid-bubble.
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0010_0213, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    check("b_retired", retired_count, 4);
    check("b_last", last_issued, 32'h0010_0213);

    // Overfill with run low, then drain.
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, rand_word(), 1'b0);
    check("c_full", 32'(full), 1);
    check("c_count", 32'(count), DEPTH);
    check("c_overflow", 32'(overflow), 1);
    drain(400);
    check("c_retired", retired_count, DEPTH);

    // Push and pop together at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_word(), 1'b0);
    run_until_slot(1'b0, 20);
    marker = 32'hABCD_E093;
    cycle(1'b1, marker, 1'b1);
    check("d_count", 32'(count), DEPTH);
    check("d_overflow", 32'(overflow), 0);
    drain(400);
    check("d_last", last_issued, marker);

    // Drop run during a real instruction, then reset with 4 queued.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 20 && !m_real; i++) cycle(1'b0, '0, 1'b1);
    check("e_busy", 32'(busy), 1);
    run = 1'b0;
    run_until_slot(1'b0, 20);
    check("e_retired", retired_count, 1);
    check("e_count", 32'(count), 4);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(9, 0) < 4, rand_word(), $urandom_range(9, 0) < 8);

`ifdef FEEDER_SYSTEM_HALT_EN
    // SYSTEM word halts issue until run is cycled.
    do_reset();
    fixed_lat = 2;
    cycle(1'b1, 32'h0050_0093, 1'b0);
    cycle(1'b1, 32'h0000_0073, 1'b0);
    cycle(1'b1, 32'h0010_0113, 1'b0);
    for (int i = 0; i < 30 && !m_halted; i++) cycle(1'b0, '0, 1'b1);
    check("h_halted", 32'(halted), 1);
    check("h_retired1", retired_count, 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    check("h_count", 32'(count), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 30 && m_halted; i++) cycle(1'b0, '0, 1'b1);
    check("h_released", 32'(halted), 0);
    drain(40);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    check("h_retired2", retired_count, 2);
    check("h_last", last_issued, 32'h0010_0113);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
